// File: rtl/timing_irq_6502.sv
// Timing-state and interrupt sequencer for the 6502 core.
// Tracks the one-hot T state and the SD1/SD2 read-modify-write cycles that
// the decoder consumes, and arbitrates RESET, edge NMI and level IRQ into
// active-low requests.

// Single-bit input conditioner: two-flop synchroniser advanced on clk_en,
// or a straight wire when synchronisation is disabled.
module timing_irq_6502_sync #(
  parameter int EN = 1
) (
  input  logic clk,
  input  logic nRESET,
  input  logic clk_en,
  input  logic d,
  output logic q
);
  generate
    if (EN != 0) begin : g_sync
      logic s1, s2;
      // Flops idle high so a low input after reset reads as a fresh edge.
      always_ff @(posedge clk) begin
        if (!nRESET) begin
          s1 <= 1'b1;
          s2 <= 1'b1;
        end else if (clk_en) begin
          s1 <= d;
          s2 <= s1;
        end
      end
      assign q = s2;
    end else begin : g_direct
      assign q = d;
    end
  endgenerate
endmodule

module timing_irq_6502 #(
  parameter int T_WIDTH  = 6,
  parameter int N_IRQ    = 4,
  parameter int NMI_SYNC = 1,
  parameter int ID_W     = 3
) (
  input  logic               clk,
  input  logic               nRESET,
  input  logic               clk_en,
  input  logic               READY,
  input  logic               RnW,
  input  logic               NEXT_T,
  input  logic               CLEAR_T,
  input  logic               PSR_I,
  input  logic               VEC_ack,
  input  logic               nNMI,
  input  logic [N_IRQ-1:0]   nIRQ,
  output logic [T_WIDTH-1:0] T_state,
  output logic               SD1,
  output logic               SD2,
  output logic               RESET_req,
  output logic               NMI_req,
  output logic               IRQ_req,
  output logic [ID_W-1:0]    IRQ_ID,
  output logic               FORCE_BRK,
  output logic               STALL
);
  localparam logic [T_WIDTH-1:0] T0 = T_WIDTH'(1);
  localparam logic [T_WIDTH-1:0] T1 = T_WIDTH'(2);

  logic             advance;
  logic             nnmi_s;
  logic             nmi_prev;
  logic             nmi_edge;
  logic [N_IRQ-1:0] nirq_s;
  logic [ID_W-1:0]  irq_id_nxt;
  logic             irq_any;

  // Write cycles never stall: the bus drives data regardless of READY.
  assign advance   = clk_en & (READY | ~RnW);
  assign STALL     = clk_en & ~READY & RnW;
  assign nmi_edge  = nmi_prev & ~nnmi_s;
  assign irq_any   = |(~nirq_s);
  assign FORCE_BRK = T_state[1] & ~(RESET_req & NMI_req & IRQ_req);

  // Input conditioning runs on every clk_en, including stalled cycles.
  timing_irq_6502_sync #(.EN(NMI_SYNC)) u_nmi_sync (
    .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .d(nNMI), .q(nnmi_s)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_irq
      timing_irq_6502_sync #(.EN(NMI_SYNC)) u_irq_sync (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .d(nIRQ[gi]), .q(nirq_s[gi])
      );
    end
  endgenerate

  // Lowest-index asserted source wins; scan high to low so it lands last.
  always_comb begin
    irq_id_nxt = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (!nirq_s[i]) irq_id_nxt = ID_W'(i);
  end

  // Timing-state sequencer; moves only on non-stalled enabled cycles.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      T_state <= T1;
      SD1     <= 1'b0;
      SD2     <= 1'b0;
    end else if (advance) begin
      if (CLEAR_T) begin
        T_state <= '0;
        SD1     <= 1'b1;
        SD2     <= 1'b0;
      end else if (NEXT_T) begin
        if (T_state != '0) begin
          T_state <= T0;
          SD1     <= 1'b0;
          SD2     <= 1'b0;
        end else if (SD1) begin
          SD1 <= 1'b0;
          SD2 <= 1'b1;
        end else begin
          T_state <= T0;
          SD2     <= 1'b0;
        end
      end else if (T_state[0]) begin
        T_state <= T1;
        SD1     <= 1'b0;
        SD2     <= 1'b0;
      end else if (T_state != '0) begin
        // Falling off the top bit yields all-zero: the extended BRK cycle.
        T_state <= T_state << 1;
        SD1     <= 1'b0;
        SD2     <= 1'b0;
      end else if (SD1) begin
        SD1 <= 1'b0;
        SD2 <= 1'b1;
      end
    end
  end

  // Interrupt arbitration; reset discards any pending NMI.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      RESET_req <= 1'b0;
      NMI_req   <= 1'b1;
      IRQ_req   <= 1'b1;
      IRQ_ID    <= '0;
      nmi_prev  <= 1'b1;
    end else if (clk_en) begin
      nmi_prev <= nnmi_s;
      // A new edge beats a simultaneous ack so back-to-back NMIs survive.
      if (nmi_edge)                  NMI_req <= 1'b0;
      else if (VEC_ack && RESET_req) NMI_req <= 1'b1;
      if (VEC_ack) RESET_req <= 1'b1;
      IRQ_req <= ~(irq_any & ~PSR_I);
      IRQ_ID  <= irq_id_nxt;
    end
  end
endmodule

// File: tb/tb_timing_irq_6502.sv
// Directed bench for timing_irq_6502 with default parameters.
module tb_timing_irq_6502;
  logic       clk = 1'b0;
  logic       nRESET = 1'b0, clk_en = 1'b1, READY = 1'b1, RnW = 1'b1;
  logic       NEXT_T = 1'b0, CLEAR_T = 1'b0, PSR_I = 1'b0, VEC_ack = 1'b0, nNMI = 1'b1;
  logic [3:0] nIRQ = 4'hF;
  logic [5:0] T_state;
  logic       SD1, SD2, RESET_req, NMI_req, IRQ_req, FORCE_BRK, STALL;
  logic [2:0] IRQ_ID;
  int         errors = 0, checks = 0;

  timing_irq_6502 dut (
    .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .READY(READY), .RnW(RnW),
    .NEXT_T(NEXT_T), .CLEAR_T(CLEAR_T), .PSR_I(PSR_I), .VEC_ack(VEC_ack),
    .nNMI(nNMI), .nIRQ(nIRQ), .T_state(T_state), .SD1(SD1), .SD2(SD2),
    .RESET_req(RESET_req), .NMI_req(NMI_req), .IRQ_req(IRQ_req),
    .IRQ_ID(IRQ_ID), .FORCE_BRK(FORCE_BRK), .STALL(STALL)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nRESET = 1'b0; step(); step();
    checks++; if (T_state !== 6'h02) begin errors++; $display("FAIL reset_T got=%h exp=02", T_state); end
    checks++; if ({SD1, SD2} !== 2'b00) begin errors++; $display("FAIL reset_SD got=%b exp=00", {SD1, SD2}); end
    checks++; if ({RESET_req, NMI_req, IRQ_req} !== 3'b011) begin errors++; $display("FAIL reset_req got=%b exp=011", {RESET_req, NMI_req, IRQ_req}); end
    checks++; if (IRQ_ID !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", IRQ_ID); end
    checks++; if (FORCE_BRK !== 1'b1) begin errors++; $display("FAIL reset_force_brk got=%b exp=1", FORCE_BRK); end
    nRESET = 1'b1;
  endtask

  task automatic test_brk_sequence();
    logic [5:0] exp_t [5] = '{6'h04, 6'h08, 6'h10, 6'h20, 6'h00};
    for (int i = 0; i < 5; i++) begin
      VEC_ack = (i == 4);
      step();
      checks++; if (T_state !== exp_t[i]) begin errors++; $display("FAIL brk_T%0d got=%h exp=%h", i, T_state, exp_t[i]); end
      if (i == 3) begin
        checks++; if (RESET_req !== 1'b0) begin errors++; $display("FAIL brk_reset_pre got=%b exp=0", RESET_req); end
      end
    end
    VEC_ack = 1'b0;
    checks++; if (RESET_req !== 1'b1) begin errors++; $display("FAIL brk_reset_post got=%b exp=1", RESET_req); end
    checks++; if (NMI_req !== 1'b1) begin errors++; $display("FAIL brk_nmi got=%b exp=1", NMI_req); end
  endtask

  task automatic test_two_cycle();
    NEXT_T = 1'b1; step();
    checks++; if (T_state !== 6'h01) begin errors++; $display("FAIL two_T0 got=%h exp=01", T_state); end
    NEXT_T = 1'b0; step();
    checks++; if (T_state !== 6'h02 || FORCE_BRK !== 1'b0) begin errors++; $display("FAIL two_T1 got=%h/%b exp=02/0", T_state, FORCE_BRK); end
    NEXT_T = 1'b1; step();
    checks++; if (T_state !== 6'h01 || {SD1, SD2} !== 2'b00) begin errors++; $display("FAIL two_next got=%h/%b exp=01/00", T_state, {SD1, SD2}); end
    NEXT_T = 1'b0; step();
    checks++; if (T_state !== 6'h02 || FORCE_BRK !== 1'b0) begin errors++; $display("FAIL two_wrap got=%h/%b exp=02/0", T_state, FORCE_BRK); end
  endtask

  task automatic test_rmw();
    step();
    checks++; if (T_state !== 6'h04) begin errors++; $display("FAIL rmw_T2 got=%h exp=04", T_state); end
    CLEAR_T = 1'b1; step(); CLEAR_T = 1'b0;
    checks++; if (T_state !== 6'h00 || {SD1, SD2} !== 2'b10) begin errors++; $display("FAIL rmw_sd1 got=%h/%b exp=00/10", T_state, {SD1, SD2}); end
    NEXT_T = 1'b1; step();
    checks++; if (T_state !== 6'h00 || {SD1, SD2} !== 2'b01) begin errors++; $display("FAIL rmw_sd2 got=%h/%b exp=00/01", T_state, {SD1, SD2}); end
    step(); NEXT_T = 1'b0;
    checks++; if (T_state !== 6'h01 || {SD1, SD2} !== 2'b00) begin errors++; $display("FAIL rmw_exit got=%h/%b exp=01/00", T_state, {SD1, SD2}); end
  endtask

  task automatic test_stall();
    step(); step();
    checks++; if (T_state !== 6'h04) begin errors++; $display("FAIL stall_setup got=%h exp=04", T_state); end
    READY = 1'b0; RnW = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL stall_flag%0d got=%b exp=1", i, STALL); end
      step();
      checks++; if (T_state !== 6'h04) begin errors++; $display("FAIL stall_hold%0d got=%h exp=04", i, T_state); end
    end
    RnW = 1'b0; #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL stall_write got=%b exp=0", STALL); end
    step(); step(); step();
    checks++; if (T_state !== 6'h20) begin errors++; $display("FAIL stall_write_adv got=%h exp=20", T_state); end
    clk_en = 1'b0; RnW = 1'b1; #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL stall_noen got=%b exp=0", STALL); end
    step(); step();
    checks++; if (T_state !== 6'h20) begin errors++; $display("FAIL clk_en_hold got=%h exp=20", T_state); end
    clk_en = 1'b1; READY = 1'b1;
    NEXT_T = 1'b1; step(); NEXT_T = 1'b0;
    checks++; if (T_state !== 6'h01) begin errors++; $display("FAIL stall_resume got=%h exp=01", T_state); end
  endtask

  task automatic test_nmi_irq();
    READY = 1'b0; RnW = 1'b1; PSR_I = 1'b0; nIRQ = 4'b1011; nNMI = 1'b0;
    step();
    checks++; if (NMI_req !== 1'b1) begin errors++; $display("FAIL nmi_early got=%b exp=1", NMI_req); end
    step(); step();
    checks++; if (NMI_req !== 1'b0) begin errors++; $display("FAIL nmi_stalled got=%b exp=0", NMI_req); end
    checks++; if (IRQ_req !== 1'b0 || IRQ_ID !== 3'd2) begin errors++; $display("FAIL irq_src2 got=%b/%0d exp=0/2", IRQ_req, IRQ_ID); end
    checks++; if (T_state !== 6'h01) begin errors++; $display("FAIL nmi_stall_T got=%h exp=01", T_state); end
    READY = 1'b1; VEC_ack = 1'b1; step(); VEC_ack = 1'b0;
    checks++; if (NMI_req !== 1'b1 || IRQ_req !== 1'b0) begin errors++; $display("FAIL nmi_ack got=%b/%b exp=1/0", NMI_req, IRQ_req); end
    PSR_I = 1'b1; step();
    checks++; if (IRQ_req !== 1'b1 || IRQ_ID !== 3'd2) begin errors++; $display("FAIL irq_masked got=%b/%0d exp=1/2", IRQ_req, IRQ_ID); end
  endtask

  task automatic test_nmi_ack_collision();
    nNMI = 1'b1; step(); step(); step();
    nNMI = 1'b0; step(); step(); step();
    checks++; if (NMI_req !== 1'b0) begin errors++; $display("FAIL nmi_first got=%b exp=0", NMI_req); end
    nNMI = 1'b1; step(); step(); step();
    checks++; if (NMI_req !== 1'b0) begin errors++; $display("FAIL nmi_held got=%b exp=0", NMI_req); end
    nNMI = 1'b0; step(); step();
    VEC_ack = 1'b1; step(); VEC_ack = 1'b0;
    checks++; if (NMI_req !== 1'b0) begin errors++; $display("FAIL nmi_collision got=%b exp=0", NMI_req); end
    VEC_ack = 1'b1; step(); VEC_ack = 1'b0;
    checks++; if (NMI_req !== 1'b1) begin errors++; $display("FAIL nmi_clear got=%b exp=1", NMI_req); end
  endtask

  task automatic test_irq_id();
    PSR_I = 1'b0; nIRQ = 4'b1010; step(); step(); step();
    checks++; if (IRQ_ID !== 3'd0 || IRQ_req !== 1'b0) begin errors++; $display("FAIL irq_1010 got=%0d/%b exp=0/0", IRQ_ID, IRQ_req); end
    nIRQ = 4'b0111; step(); step(); step();
    checks++; if (IRQ_ID !== 3'd3 || IRQ_req !== 1'b0) begin errors++; $display("FAIL irq_0111 got=%0d/%b exp=3/0", IRQ_ID, IRQ_req); end
    nIRQ = 4'b1111; step(); step(); step();
    checks++; if (IRQ_ID !== 3'd0 || IRQ_req !== 1'b1) begin errors++; $display("FAIL irq_none got=%0d/%b exp=0/1", IRQ_ID, IRQ_req); end
  endtask

  task automatic test_reset_abort();
    nNMI = 1'b1; step(); step(); step();
    nNMI = 1'b0; step(); step(); step();
    checks++; if (NMI_req !== 1'b0) begin errors++; $display("FAIL abort_setup got=%b exp=0", NMI_req); end
    nRESET = 1'b0; nNMI = 1'b1; step(); nRESET = 1'b1;
    checks++; if (T_state !== 6'h02 || {RESET_req, NMI_req} !== 2'b01) begin errors++; $display("FAIL abort_reset got=%h/%b exp=02/01", T_state, {RESET_req, NMI_req}); end
    step(); step(); step();
    checks++; if (NMI_req !== 1'b1) begin errors++; $display("FAIL abort_discard got=%b exp=1", NMI_req); end
  endtask

  initial begin
    test_reset();
    test_brk_sequence();
    test_two_cycle();
    test_rmw();
    test_stall();
    test_nmi_irq();
    test_nmi_ack_collision();
    test_irq_id();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timing_irq_6502.md
Name: timing_irq_6502

Overview:
- Parametrised timing-state and interrupt sequencer for the 6502 core.
- Holds the one-hot T_state and the SD1/SD2 special states that the instruction decoder consumes.
- Advances the state from the decoder's NEXT_T/CLEAR_T, applies READY stalls, and arbitrates RESET, edge-triggered NMI and multi-source level IRQ.
- Produces the active-low RESET_req/NMI_req/IRQ_req that the decoder consumes.

Parameters:
T_WIDTH, 6, number of one-hot timing states T0..T(T_WIDTH-1); range 6..8
N_IRQ, 4, number of independent active-low IRQ sources; range 1..8
NMI_SYNC, 1, 1 = two-flop synchroniser on nNMI/nIRQ; 0 = sample inputs directly
ID_W, 3, width of IRQ_ID; must be >= clog2(N_IRQ), minimum 1

Ports:
clk  in  1  system clock
nRESET  in  1  synchronous active-low reset
clk_en  in  1  CPU cycle enable; all state changes are qualified by it
READY  in  1  1 = memory ready; 0 stalls read cycles
RnW  in  1  current cycle direction from the decoder
NEXT_T  in  1  decoder: jump to T0 (or exit special state)
CLEAR_T  in  1  decoder: enter SD1 (RMW path)
PSR_I  in  1  interrupt-disable flag
VEC_ack  in  1  pulse, high in the vector-fetch cycle of the BRK sequence
nNMI  in  1  active-low NMI, falling-edge sensitive
nIRQ  in  N_IRQ  active-low level IRQ sources
T_state  out  T_WIDTH  one-hot timing state; all-zero = special state
SD1  out  1  first RMW special cycle
SD2  out  1  second RMW special cycle
RESET_req  out  1  active-low, reset pending
NMI_req  out  1  active-low, NMI pending
IRQ_req  out  1  active-low, unmasked IRQ pending
IRQ_ID  out  ID_W  index of the highest-priority pending source
FORCE_BRK  out  1  force IR to 00 on this opcode fetch
STALL  out  1  cycle held by READY

Behaviour:
- Reset (nRESET=0 at clk edge, regardless of clk_en):
  - T_state = 'b10 (T1); SD1 = SD2 = 0.
  - RESET_req = 0; NMI_req = 1; IRQ_req = 1; IRQ_ID = 0.
  - NMI latch cleared; synchroniser flops = 1; previous-nNMI register = 1.
- advance = clk_en & (READY | ~RnW). STALL = clk_en & ~READY & RnW (combinational). Write cycles never stall.
- T_state/SD update on advance only, in priority order:
  1. CLEAR_T: T_state <= 0, SD1 <= 1, SD2 <= 0.
  2. NEXT_T, T_state != 0: T_state <= T0.
  3. NEXT_T, T_state == 0, SD1 = 1: SD1 <= 0, SD2 <= 1.
  4. NEXT_T, T_state == 0, SD1 = 0: T_state <= T0, SD2 <= 0.
  5. No NEXT_T, T0 active: T_state <= T1.
  6. No NEXT_T, other T active: shift left one place. Shifting out of T(T_WIDTH-1) gives 0 (the extended BRK cycle).
  7. No NEXT_T, T_state == 0: hold; SD1 advances to SD2 unconditionally.
- SD1 and SD2 are never both 1. A nonzero T_state forces SD1 = SD2 = 0.
- Synchroniser and NMI edge detector run on every clk_en, stalled or not, so edges are never lost.
- NMI:
  - Latch sets on a synced 1->0 transition of nNMI.
  - Latch clears on VEC_ack when RESET_req = 1.
  - A new edge in the same cycle as the clearing ack keeps the latch set.
  - NMI_req = ~latch, registered.
- IRQ:
  - On each clk_en: IRQ_req <= ~(|~nIRQ_sync & ~PSR_I).
  - IRQ_ID <= lowest-index asserted source, or 0 if none.
  - Level-sensitive, not latched: a source withdrawn before sampling is lost.
- RESET_req: returns to 1 on the first VEC_ack after reset. It has priority, so VEC_ack does not clear NMI while RESET_req = 0.
- FORCE_BRK = T_state[1] & ~(RESET_req & NMI_req & IRQ_req) (combinational).
- Reset mid-instruction aborts the sequence; any pending NMI is discarded.

Test Plan:
- Reset, then advance with NEXT_T=0 and a VEC_ack pulse at T5 -> T_state 02,04,08,10,20,00; FORCE_BRK=1 in the first cycle; RESET_req rises after the ack.
- Two-cycle opcode (NEXT_T=1 at T1) -> T_state 02,01,02; FORCE_BRK=0; no SD1/SD2.
- CLEAR_T at T2, then NEXT_T=1 on each following cycle -> T_state 00 with SD1=1, then SD2=1, then T_state=01 with SD1=SD2=0.
- READY=0 for 3 cycles:
  - with RnW=1 at T2 -> T_state holds 04 and STALL=1 for those cycles.
  - with RnW=0 -> state advances and STALL=0.
- nNMI falls while stalled; an IRQ on source 2 with PSR_I=0 is also pending:
  - NMI_req=0 two cycles after the edge; IRQ_ID=2 and IRQ_req=0.
  - VEC_ack -> NMI_req=1, IRQ_req stays 0.
  - Setting PSR_I=1 -> IRQ_req=1.
- Second nNMI falling edge aligned with VEC_ack -> NMI_req stays 0.
- nIRQ='b1010 -> IRQ_ID=0.
